// File: rtl/rst_seq_pkg.sv
// Shared types and constants for the reset release sequencer.
// Optional feature macro used by rst_seq_ctrl: RST_SEQ_TIMEOUT_EN (ack timeout and ERR state).
package rst_seq_pkg;

  localparam int CNT_W = 10;

  typedef enum logic [2:0] {
    HOLD,
    WAIT_ACK,
    GAP,
    DONE,
    ERR
  } state_e;

  // Width of a domain index; never narrower than one bit.
  function automatic int dom_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rst_seq_cnt.sv
// Clear/enable up-counter with a terminal-count compare, shared by every
// sequencer state.
module rst_seq_cnt
  import rst_seq_pkg::*;
#(
  parameter int W = CNT_W
) (
  input  logic         clk,
  input  logic         por,
  input  logic         clr_i,
  input  logic         en_i,
  input  logic [W-1:0] tc_val_i,
  output logic         tc_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  // NOTE: state registers use non-blocking assignments only, so every flop
  // samples the values from before the edge regardless of block ordering.
  always_ff @(posedge clk) begin
    if (por) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = (cnt_q == tc_val_i);

endmodule

// File: rtl/rst_seq_ctrl.sv
// Reset release sequencer: holds all domains in reset, then releases them in
// index order, waiting for each ack. Optional macro: RST_SEQ_TIMEOUT_EN.
module rst_seq_ctrl
  import rst_seq_pkg::*;
#(
  parameter int NUM_DOM  = 4,
  parameter int HOLD_CYC = 16,
  parameter int GAP_CYC  = 8,
  parameter int ACK_TO   = 255,
  localparam int DW      = dom_w(NUM_DOM)
) (
  input  logic               clk,
  input  logic               por,
  input  logic               rst_req,
  input  logic               sw_rst_req,
  input  logic [NUM_DOM-1:0] dom_ready,
  output logic [NUM_DOM-1:0] dom_rst_n,
  output logic [DW-1:0]      cur_dom,
  output logic               seq_busy,
  output logic               seq_done,
  output logic               seq_err,
  output logic [DW-1:0]      err_dom
);

  state_e             state_q, state_d;
  logic [NUM_DOM-1:0] dom_rst_n_q, dom_rst_n_d;
  logic [DW-1:0]      cur_dom_q, cur_dom_d;
  logic               seq_busy_q, seq_done_q;

  logic               req;
  logic               ack;
  logic [DW-1:0]      nxt_dom;
  logic [NUM_DOM-1:0] nxt_mask;
  logic               cnt_clr, cnt_en, cnt_tc;
  logic [CNT_W-1:0]   tc_val;

  assign req = rst_req | sw_rst_req;

  // Only the domain currently awaited is looked at; earlier acks are ignored.
  always_comb begin
    ack      = 1'b0;
    nxt_dom  = cur_dom_q + DW'(1);
    nxt_mask = '0;
    for (int i = 0; i < NUM_DOM; i++) begin
      if (DW'(i) == cur_dom_q) ack = dom_ready[i];
      if (DW'(i) == nxt_dom)   nxt_mask[i] = 1'b1;
    end
  end

  always_comb begin
    tc_val = '0;
    case (state_q)
      HOLD:     tc_val = CNT_W'(HOLD_CYC - 1);
      WAIT_ACK: tc_val = CNT_W'(ACK_TO - 1);
      GAP:      tc_val = CNT_W'(GAP_CYC);
      default:  tc_val = '0;
    endcase
  end

  // NOTE: every variable assigned here gets a default first, so no path
  // through the case leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    dom_rst_n_d = dom_rst_n_q;
    cur_dom_d   = cur_dom_q;
    cnt_en      = 1'b0;
    if (req) begin
      state_d     = HOLD;
      dom_rst_n_d = '0;
      cur_dom_d   = '0;
    end else begin
      case (state_q)
        HOLD: begin
          cnt_en = 1'b1;
          if (cnt_tc) begin
            state_d     = WAIT_ACK;
            cur_dom_d   = '0;
            dom_rst_n_d = NUM_DOM'(1);
          end
        end
        WAIT_ACK: begin
          if (ack) begin
            state_d = (cur_dom_q == DW'(NUM_DOM - 1)) ? DONE : GAP;
          end
`ifdef RST_SEQ_TIMEOUT_EN
          else if (cnt_tc) begin
            state_d = ERR;
          end else begin
            cnt_en = 1'b1;
          end
`endif
        end
        GAP: begin
          cnt_en = 1'b1;
          if (cnt_tc) begin
            state_d     = WAIT_ACK;
            cur_dom_d   = nxt_dom;
            dom_rst_n_d = dom_rst_n_q | nxt_mask;
          end
        end
        DONE:    dom_rst_n_d = '1;
        ERR:     state_d = ERR;
        default: state_d = HOLD;
      endcase
    end
  end

  // The counter restarts on every state change and on any request.
  assign cnt_clr = req | (state_d != state_q);

  rst_seq_cnt #(
    .W(CNT_W)
  ) u_cnt (
    .clk      (clk),
    .por      (por),
    .clr_i    (cnt_clr),
    .en_i     (cnt_en),
    .tc_val_i (tc_val),
    .tc_o     (cnt_tc)
  );

  always_ff @(posedge clk) begin
    if (por) begin
      state_q     <= HOLD;
      dom_rst_n_q <= '0;
      cur_dom_q   <= '0;
      seq_busy_q  <= 1'b1;
      seq_done_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      dom_rst_n_q <= dom_rst_n_d;
      cur_dom_q   <= cur_dom_d;
      seq_busy_q  <= (state_d == HOLD) || (state_d == WAIT_ACK) || (state_d == GAP);
      seq_done_q  <= (state_d == DONE);
    end
  end

`ifdef RST_SEQ_TIMEOUT_EN
  logic          seq_err_q;
  logic [DW-1:0] err_dom_q;

  // Error flags survive requests; only a fresh completion or por clears them.
  always_ff @(posedge clk) begin
    if (por) begin
      seq_err_q <= 1'b0;
      err_dom_q <= '0;
    end else if (state_d == DONE && state_q != DONE) begin
      seq_err_q <= 1'b0;
      err_dom_q <= '0;
    end else if (state_d == ERR && state_q == WAIT_ACK) begin
      seq_err_q <= 1'b1;
      err_dom_q <= cur_dom_q;
    end
  end

  assign seq_err = seq_err_q;
  assign err_dom = err_dom_q;
`else
  assign seq_err = 1'b0;
  assign err_dom = '0;
`endif

  assign dom_rst_n = dom_rst_n_q;
  assign cur_dom   = cur_dom_q;
  assign seq_busy  = seq_busy_q;
  assign seq_done  = seq_done_q;

endmodule

// File: doc/rst_seq_ctrl.md
# rst_seq_ctrl

Reset release sequencer that sits downstream of the filtered, synchronised reset request produced by the rst_filter stage. It holds all chip reset domains in reset, then releases them one at a time in fixed index order. Each domain must acknowledge readiness before the next is released. Any new reset request restarts the whole sequence.

## Interface
- NUM_DOM, 4, number of reset domains, 2..8
- HOLD_CYC, 16, minimum clean cycles before the first release, 1..255
- GAP_CYC, 8, idle cycles between one domain's ack and the next release, 1..255
- ACK_TO, 255, maximum cycles to wait for dom_ready, 1..1023
- clk  in  1  single block clock, rising edge
- por  in  1  reset, synchronous, active-high
- rst_req  in  1  filtered reset request, level, active-high, synchronous to clk
- sw_rst_req  in  1  software reset request, one-cycle pulse
- dom_ready  in  NUM_DOM  per-domain ready ack, level; only bit cur_dom is sampled
- dom_rst_n  out  NUM_DOM  per-domain reset, active-low, registered
- cur_dom  out  clog2(NUM_DOM)  index of the domain being released or awaited
- seq_busy  out  1  sequence in progress
- seq_done  out  1  all domains released and acked
- seq_err  out  1  ack timeout occurred
- err_dom  out  clog2(NUM_DOM)  domain that timed out

## Operation
- States: HOLD, WAIT_ACK, GAP, DONE, ERR. The state after por is HOLD.
- Any request is a cycle with rst_req=1 or sw_rst_req=1.
- HOLD:
  - All dom_rst_n are 0. A request clears cnt; otherwise cnt increments.
  - When cnt==HOLD_CYC-1 with no request: go to WAIT_ACK, set cur_dom=0, and set dom_rst_n[0]=1 on the same edge.
- WAIT_ACK:
  - cnt counts cycles. If dom_ready[cur_dom]=1 and cur_dom==NUM_DOM-1: go to DONE.
  - If dom_ready[cur_dom]=1 otherwise: go to GAP with cnt=0.
  - Timeout (RST_SEQ_TIMEOUT_EN only): cnt==ACK_TO-1 with no ack → go to ERR, set seq_err=1 and err_dom=cur_dom.
- GAP:
  - After GAP_CYC cycles: cur_dom increments, dom_rst_n[cur_dom+1] is set to 1, go to WAIT_ACK with cnt=0.
- DONE: all dom_rst_n are 1; seq_done=1.
- ERR:
  - Released domains stay released; unreleased domains stay in reset.
  - Stays in ERR until a request arrives.
- A request in any state:
  - Next edge: state HOLD, cnt=0, cur_dom=0, all dom_rst_n=0.
  - seq_done clears. seq_err and err_dom stay sticky; they clear only on por or on the next entry to DONE.
- A request wins over a simultaneous ack, timeout or gap expiry.
- dom_ready of already-acked domains is not monitored. dom_ready[cur_dom] already high on entry to WAIT_ACK is accepted on the first WAIT_ACK cycle.
- cnt is a single 10-bit counter shared by all states and zeroed on every state change. It never wraps, because every terminal count causes a state exit.

## Timing
- Reset values while por=1: dom_rst_n=0, cur_dom=0, seq_busy=1, seq_done=0, seq_err=0, err_dom=0, state HOLD, cnt=0.
- por asserted mid-sequence takes priority over everything and gives the same values on the next edge.
- All outputs are registered with no combinational path from inputs.
- seq_busy=1 in HOLD, WAIT_ACK and GAP; 0 in DONE and ERR.
- Release timing:
  - dom_rst_n[0] rises HOLD_CYC edges after the first cycle with por=0 and no request.
  - dom_rst_n[i+1] rises GAP_CYC+1 edges after the edge that samples dom_ready[i]=1.
- seq_done rises one edge after the sampled ack of domain NUM_DOM-1.
- Reassert latency after a request: 1 edge.

## Configuration
- RST_SEQ_TIMEOUT_EN defined: the ACK_TO timeout and ERR state are implemented.
- Macro undefined:
  - WAIT_ACK waits indefinitely and ERR is unreachable.
  - seq_err and err_dom are tied to 0.
  - The ACK_TO parameter is ignored.

## Structure
- Package rst_seq_pkg: state enum (HOLD, WAIT_ACK, GAP, DONE, ERR), CNT_W=10 constant, domain-index width function.
- Sub-module rst_seq_cnt: clear/enable counter with terminal-count compare, instantiated once and shared by all states.
- The top module holds the FSM, the dom_rst_n register bank and the error capture.

## Test plan
Common setup: NUM_DOM=3, HOLD_CYC=4, GAP_CYC=2, ACK_TO=10.
- Nominal sequence: por released, dom_ready tied to 3'b111 → dom_rst_n goes 000→001 at edge 4, 011 at edge 8, 111 at edge 12; seq_done=1 at edge 13.
- Request in HOLD: rst_req pulsed high at cycle 2 after por → HOLD count restarts; dom_rst_n[0] rises 4 edges after rst_req falls.
- Request mid-sequence: sw_rst_req during GAP after domain 0 acks → next edge dom_rst_n=000, cur_dom=0, seq_busy=1.
- Timeout (macro defined): dom_ready[1] held 0 → ERR 10 cycles after dom_rst_n[1] rises; seq_err=1, err_dom=1, dom_rst_n=011.
- Timeout disabled (macro undefined): same stimulus → stays in WAIT_ACK indefinitely; raising dom_ready[1] after 500 cycles resumes the sequence normally.
- Simultaneous events: rst_req and dom_ready[2] both high on the final ack cycle → HOLD, seq_done stays 0.
